// File: rtl/regpair_sequencer.sv
// rtl/regpair_sequencer.sv - two-requester command sequencer driving a register pair
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid_k / req_ready_k       per-requester command handshake (k = 0, 1)
//   req_op_k                        00 NOP, 01 LOAD, 10 READ, 11 MOVE
//   req_sel_k                       target register (0 = register 1, 1 = register 2)
//   req_data_k                      LOAD payload
//   rsp_valid / rsp_id / rsp_data   one-cycle response pulse, no backpressure
//   busy                            high whenever the sequencer is not idle
//   write_enable_x, read_enable_x,
//   data_in_x                       register pair control (x = 1, 2)
//   data_out_x                      register pair read-back
module regpair_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid_0,
    input  logic       req_valid_1,
    input  logic [1:0] req_op_0,
    input  logic [1:0] req_op_1,
    input  logic       req_sel_0,
    input  logic       req_sel_1,
    input  logic [1:0] req_data_0,
    input  logic [1:0] req_data_1,
    output logic       req_ready_0,
    output logic       req_ready_1,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [1:0] rsp_data,
    output logic       busy,
    output logic       write_enable_1,
    output logic       write_enable_2,
    output logic       read_enable_1,
    output logic       read_enable_2,
    output logic [1:0] data_in_1,
    output logic [1:0] data_in_2,
    input  logic [1:0] data_out_1,
    input  logic [1:0] data_out_2
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC_WR = 3'd1,
        RD1     = 3'd2,
        RD2     = 3'd3,
        MV_WR   = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    state_t     state;
    logic       ptr;
    logic [1:0] op_l;
    logic       sel_l;
    logic [1:0] data_l;
    logic       id_l;
    logic [1:0] cap;

    logic       any_valid;
    logic       g_id;
    logic [1:0] g_op;
    logic       g_sel;
    logic [1:0] g_data;
    logic [1:0] rd_val;

    // Round-robin pointer only matters when both requesters contend.
    assign any_valid = req_valid_0 | req_valid_1;
    assign g_id      = (req_valid_0 & req_valid_1) ? ptr : req_valid_1;
    assign g_op      = g_id ? req_op_1   : req_op_0;
    assign g_sel     = g_id ? req_sel_1  : req_sel_0;
    assign g_data    = g_id ? req_data_1 : req_data_0;
    assign rd_val    = sel_l ? data_out_2 : data_out_1;

    // Ready is the live grant, so it must stay combinational; reset masks it
    // so no command can be accepted on a reset edge.
    assign req_ready_0 = ~reset & (state == IDLE) & any_valid & ~g_id;
    assign req_ready_1 = ~reset & (state == IDLE) & any_valid &  g_id;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            op_l           <= 2'b00;
            sel_l          <= 1'b0;
            data_l         <= 2'b00;
            id_l           <= 1'b0;
            cap            <= 2'b00;
            write_enable_1 <= 1'b0;
            write_enable_2 <= 1'b0;
            read_enable_1  <= 1'b0;
            read_enable_2  <= 1'b0;
            data_in_1      <= 2'b00;
            data_in_2      <= 2'b00;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_data       <= 2'b00;
        end else begin
            // Outputs describe the state being entered; anything not set
            // below returns to its idle value.
            write_enable_1 <= 1'b0;
            write_enable_2 <= 1'b0;
            read_enable_1  <= 1'b0;
            read_enable_2  <= 1'b0;
            data_in_1      <= 2'b00;
            data_in_2      <= 2'b00;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_data       <= 2'b00;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_l   <= g_op;
                        sel_l  <= g_sel;
                        data_l <= g_data;
                        id_l   <= g_id;
                        ptr    <= ~g_id;
                        if (g_op == OP_NOP) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_id    <= g_id;
                        end else if (g_op == OP_LOAD) begin
                            state <= EXEC_WR;
                            if (g_sel) begin
                                write_enable_2 <= 1'b1;
                                data_in_2      <= g_data;
                            end else begin
                                write_enable_1 <= 1'b1;
                                data_in_1      <= g_data;
                            end
                        end else begin
                            state         <= RD1;
                            read_enable_1 <= ~g_sel;
                            read_enable_2 <= g_sel;
                        end
                    end
                end
                EXEC_WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_l;
                    rsp_data  <= data_l;
                end
                RD1: begin
                    state         <= RD2;
                    read_enable_1 <= ~sel_l;
                    read_enable_2 <= sel_l;
                end
                RD2: begin
                    cap <= rd_val;
                    if (op_l == OP_READ) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_l;
                        rsp_data  <= rd_val;
                    end else begin
                        // MOVE writes the captured value into the other register.
                        state <= MV_WR;
                        if (sel_l) begin
                            write_enable_1 <= 1'b1;
                            data_in_1      <= rd_val;
                        end else begin
                            write_enable_2 <= 1'b1;
                            data_in_2      <= rd_val;
                        end
                    end
                end
                MV_WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_l;
                    rsp_data  <= cap;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
